// File: rtl/sweep_controller_pkg.sv
// Shared encodings for the DDS linear frequency sweep controller.
// Optional marker output is enabled with SWEEP_MARKER_EN.
package sweep_controller_pkg;

    typedef enum logic [1:0] {
        SW_IDLE  = 2'd0,
        SW_DWELL = 2'd1,
        SW_STEP  = 2'd2,
        SW_DONE  = 2'd3
    } sw_state_e;

    localparam logic [1:0] SW_MODE_SINGLE = 2'b00;
    localparam logic [1:0] SW_MODE_SAW    = 2'b01;
    localparam logic [1:0] SW_MODE_TRI    = 2'b10;
    localparam logic [1:0] SW_MODE_RSVD   = 2'b11;

    // A zero step is only usable when there is nowhere to go.
    function automatic logic sw_cfg_ok(
        input logic [1:0] mode,
        input logic       step_zero,
        input logic       same_ends
    );
        return (mode != SW_MODE_RSVD) && !(step_zero && !same_ends);
    endfunction

endpackage

// File: rtl/sweep_controller_if.sv
// Config/command/status bundle between control_unit and sweep_controller.
// Marker signals exist only when SWEEP_MARKER_EN is defined.
interface sweep_controller_if #(
    parameter int M_W     = 11,
    parameter int DWELL_W = 16
);
    logic               tick;
    logic [M_W-1:0]     cfg_start_m;
    logic [M_W-1:0]     cfg_stop_m;
    logic [M_W-1:0]     cfg_step;
    logic [DWELL_W-1:0] cfg_dwell;
    logic [1:0]         cfg_mode;
    logic               cmd_start;
    logic               cmd_abort;
    logic [M_W-1:0]     phase_M;
    logic               busy;
    logic               sweep_done;
    logic               cfg_err;
`ifdef SWEEP_MARKER_EN
    logic [M_W-1:0]     cfg_marker_m;
    logic               marker;
`endif

    modport master (
`ifdef SWEEP_MARKER_EN
        output cfg_marker_m,
        input  marker,
`endif
        output tick,
        output cfg_start_m,
        output cfg_stop_m,
        output cfg_step,
        output cfg_dwell,
        output cfg_mode,
        output cmd_start,
        output cmd_abort,
        input  phase_M,
        input  busy,
        input  sweep_done,
        input  cfg_err
    );

    modport slave (
`ifdef SWEEP_MARKER_EN
        input  cfg_marker_m,
        output marker,
`endif
        input  tick,
        input  cfg_start_m,
        input  cfg_stop_m,
        input  cfg_step,
        input  cfg_dwell,
        input  cfg_mode,
        input  cmd_start,
        input  cmd_abort,
        output phase_M,
        output busy,
        output sweep_done,
        output cfg_err
    );

endinterface

// File: rtl/sweep_next_value.sv
// Clamped next sweep point; when already on the target it steps away
// from it (the triangle turn-around) toward the opposite endpoint.
module sweep_next_value #(
    parameter int M_W = 11
) (
    input  logic [M_W-1:0] cur,
    input  logic [M_W-1:0] step,
    input  logic [M_W-1:0] start_m,
    input  logic [M_W-1:0] stop_m,
    input  logic           fwd,
    input  logic           up0,
    output logic [M_W-1:0] next_m,
    output logic           at_target
);
    logic [M_W-1:0] target;
    logic [M_W-1:0] aim;
    logic           eff_fwd;
    logic           up;
    logic [M_W:0]   sum;
    logic [M_W:0]   diff;

    always_comb begin
        target    = fwd ? stop_m : start_m;
        at_target = (cur == target);
        eff_fwd   = at_target ? ~fwd : fwd;
        aim       = eff_fwd ? stop_m : start_m;
        up        = eff_fwd ? up0 : ~up0;
        sum       = {1'b0, cur} + {1'b0, step};
        diff      = {1'b0, cur} - {1'b0, step};
        next_m    = aim;
        if (up) begin
            if (sum <= {1'b0, aim})
                next_m = sum[M_W-1:0];
        end else begin
            if (!diff[M_W] && (diff[M_W-1:0] >= aim))
                next_m = diff[M_W-1:0];
        end
    end

endmodule

// File: rtl/sweep_controller.sv
// Linear phase_M sweep sequencer paced by the DDS sample tick.
// Define SWEEP_MARKER_EN to add the cfg_marker_m / marker crossing pulse.
module sweep_controller
    import sweep_controller_pkg::*;
#(
    parameter int M_W     = 11,
    parameter int DWELL_W = 16
) (
    input logic               clk,
    input logic               rst,
    sweep_controller_if.slave bus
);
    sw_state_e          state_q, state_n;
    logic [M_W-1:0]     phase_q, phase_n;
    logic [M_W-1:0]     start_q, stop_q, step_q;
    logic [DWELL_W-1:0] dwell_q, cnt_q, cnt_n, dwell_in;
    logic [1:0]         mode_q;
    logic               up_q, up_n, up0_q;
    logic               busy_q, busy_n;
    logic               done_q, done_n;
    logic               err_q, err_n;
    logic               load_cfg;
    logic               cfg_up;
    logic               cfg_ok;
    logic [M_W-1:0]     step_val;
    logic               at_target;

`ifdef SWEEP_MARKER_EN
    logic [M_W-1:0]     mark_q;
    logic               marker_q, marker_n;

    function automatic logic hit(
        input logic [M_W-1:0] from_v,
        input logic [M_W-1:0] to_v,
        input logic [M_W-1:0] mark,
        input logic           up
    );
        return up ? (from_v < mark && to_v >= mark)
                  : (from_v > mark && to_v <= mark);
    endfunction
`endif

    sweep_next_value #(.M_W(M_W)) u_next (
        .cur       (phase_q),
        .step      (step_q),
        .start_m   (start_q),
        .stop_m    (stop_q),
        .fwd       (up_q == up0_q),
        .up0       (up0_q),
        .next_m    (step_val),
        .at_target (at_target)
    );

    assign dwell_in = (bus.cfg_dwell == '0) ? DWELL_W'(1) : bus.cfg_dwell;
    assign cfg_up   = (bus.cfg_stop_m >= bus.cfg_start_m);
    assign cfg_ok   = sw_cfg_ok(bus.cfg_mode, bus.cfg_step == '0,
                                bus.cfg_start_m == bus.cfg_stop_m);

    always_comb begin
        state_n  = state_q;
        phase_n  = phase_q;
        cnt_n    = cnt_q;
        up_n     = up_q;
        busy_n   = busy_q;
        done_n   = 1'b0;
        err_n    = err_q;
        load_cfg = 1'b0;
`ifdef SWEEP_MARKER_EN
        marker_n = 1'b0;
`endif
        if (bus.cmd_abort && state_q != SW_IDLE) begin
            state_n = SW_IDLE;
            busy_n  = 1'b0;
        end else begin
            unique case (state_q)
                SW_IDLE: begin
                    if (bus.cmd_start && !bus.cmd_abort) begin
                        if (cfg_ok) begin
                            load_cfg = 1'b1;
                            phase_n  = bus.cfg_start_m;
                            cnt_n    = dwell_in;
                            up_n     = cfg_up;
                            busy_n   = 1'b1;
                            err_n    = 1'b0;
                            state_n  = SW_DWELL;
`ifdef SWEEP_MARKER_EN
                            marker_n = (bus.cfg_start_m == bus.cfg_marker_m);
`endif
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end
                SW_DWELL: begin
                    if (bus.tick) begin
                        if (cnt_q == DWELL_W'(1))
                            state_n = SW_STEP;
                        else
                            cnt_n = cnt_q - DWELL_W'(1);
                    end
                end
                SW_STEP: begin
                    cnt_n   = dwell_q;
                    state_n = SW_DWELL;
                    if (!at_target) begin
                        phase_n = step_val;
`ifdef SWEEP_MARKER_EN
                        marker_n = hit(phase_q, step_val, mark_q, up_q);
`endif
                    end else begin
                        unique case (mode_q)
                            SW_MODE_SAW: begin
                                phase_n = start_q;
                                up_n    = up0_q;
`ifdef SWEEP_MARKER_EN
                                marker_n = (start_q == mark_q);
`endif
                            end
                            SW_MODE_TRI: begin
                                phase_n = step_val;
                                up_n    = ~up_q;
`ifdef SWEEP_MARKER_EN
                                marker_n = hit(phase_q, step_val, mark_q, ~up_q);
`endif
                            end
                            default: begin
                                state_n = SW_DONE;
                                done_n  = 1'b1;
                                busy_n  = 1'b0;
                            end
                        endcase
                    end
                end
                SW_DONE: begin
                    state_n = SW_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SW_IDLE;
            phase_q <= '0;
            cnt_q   <= '0;
            start_q <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            mode_q  <= SW_MODE_SINGLE;
            up_q    <= 1'b1;
            up0_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            phase_q <= phase_n;
            cnt_q   <= cnt_n;
            up_q    <= up_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            err_q   <= err_n;
            if (load_cfg) begin
                start_q <= bus.cfg_start_m;
                stop_q  <= bus.cfg_stop_m;
                step_q  <= bus.cfg_step;
                dwell_q <= dwell_in;
                mode_q  <= bus.cfg_mode;
                up0_q   <= cfg_up;
            end
        end
    end

`ifdef SWEEP_MARKER_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mark_q   <= '0;
            marker_q <= 1'b0;
        end else begin
            marker_q <= marker_n;
            if (load_cfg)
                mark_q <= bus.cfg_marker_m;
        end
    end

    assign bus.marker = marker_q;
`endif

    assign bus.phase_M    = phase_q;
    assign bus.busy       = busy_q;
    assign bus.sweep_done = done_q;
    assign bus.cfg_err    = err_q;

endmodule

// File: tb/tb_sweep_controller.sv
// Scoreboard bench for sweep_controller: model pushes expected points,
// a negedge monitor pops them as phase_M loads and sweep_done appear.
module tb_sweep_controller;
    localparam int M_W     = 11;
    localparam int DWELL_W = 16;
    localparam int LIMIT   = 3000;

    typedef struct {
        bit is_done;
        int val;
        int dwell;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sweep_controller_if #(.M_W(M_W), .DWELL_W(DWELL_W)) bus ();

    sweep_controller #(.M_W(M_W), .DWELL_W(DWELL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;
    bit   tick_all = 1'b1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int step_to(input int v, input int t, input int st);
        if (t >= v) return (v + st > t) ? t : v + st;
        return (v - st < t) ? t : v - st;
    endfunction

    // Reference: list of held points built from plain arithmetic.
    task automatic push_model(input int s, input int e, input int st,
                              input int dw, input int md, input int npts,
                              output int last);
        int v, tgt, d;
        exp_t x;
        v = s;
        tgt = e;
        d = (dw == 0) ? 1 : dw;
        last = e;
        if (md == 0) begin
            while (v != e) begin
                x = '{1'b0, v, d};
                exp_q.push_back(x);
                v = step_to(v, e, st);
            end
            x = '{1'b0, e, d};
            exp_q.push_back(x);
            x = '{1'b1, e, d};
            exp_q.push_back(x);
        end else begin
            for (int n = 0; n < npts; n++) begin
                x = '{1'b0, v, d};
                exp_q.push_back(x);
                last = v;
                if (v != tgt) begin
                    v = step_to(v, tgt, st);
                end else if (md == 1) begin
                    v = s;
                end else begin
                    tgt = (tgt == e) ? s : e;
                    v = step_to(v, tgt, st);
                end
            end
        end
    endtask

    initial begin : tick_gen
        bus.tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.tick = tick_all ? 1'b1 : ($urandom_range(0, 2) != 0);
        end
    end

    logic [M_W-1:0] prev_ph = '0;
    logic           prev_busy = 1'b0;
    logic           pend = 1'b0;
    logic           last_t = 1'b0;
    int             tcnt = 0;
    int             cur_dw = 1;

    initial begin : monitor
        logic ev_load, ev_done;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst || !mon_en) begin
                tcnt = 0;
                last_t = 1'b0;
            end else begin
                ev_load = bus.busy && (!prev_busy || bus.phase_M != prev_ph);
                ev_done = bus.sweep_done;
                if (ev_load || ev_done) begin
                    if (prev_busy)
                        chk("hold_ticks", last_t ? tcnt : -1, cur_dw);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: phase_M=%0d done=%0d, none expected",
                                 bus.phase_M, bus.sweep_done);
                    end else begin
                        e = exp_q.pop_front();
                        chk("event_kind", int'(ev_done), int'(e.is_done));
                        if (ev_done)
                            chk("busy_at_done", int'(bus.busy), 0);
                        else
                            chk("point", int'(bus.phase_M), e.val);
                        cur_dw = e.dwell;
                    end
                    tcnt = 0;
                    last_t = 1'b0;
                end else begin
                    tcnt += int'(pend);
                    last_t = pend;
                end
            end
            prev_ph = bus.phase_M;
            prev_busy = bus.busy;
            pend = bus.tick;
        end
    end

`ifdef SWEEP_MARKER_EN
    int mark_cnt = 0;
    int mark_val = 0;
    int mark_m = 0;
    initial begin : marker_mon
        forever begin
            @(negedge clk);
            if (bus.marker) begin
                mark_cnt++;
                mark_val = int'(bus.phase_M);
            end
        end
    end
`endif

    task automatic set_cfg(input int s, input int e, input int st,
                           input int dw, input int md);
        bus.cfg_start_m = M_W'(s);
        bus.cfg_stop_m  = M_W'(e);
        bus.cfg_step    = M_W'(st);
        bus.cfg_dwell   = DWELL_W'(dw);
        bus.cfg_mode    = 2'(md);
`ifdef SWEEP_MARKER_EN
        bus.cfg_marker_m = M_W'(mark_m);
`endif
    endtask

    task automatic scramble_cfg();
        bus.cfg_start_m = M_W'($urandom);
        bus.cfg_stop_m  = M_W'($urandom);
        bus.cfg_step    = M_W'($urandom);
        bus.cfg_dwell   = DWELL_W'($urandom);
        bus.cfg_mode    = 2'($urandom);
`ifdef SWEEP_MARKER_EN
        bus.cfg_marker_m = M_W'($urandom);
`endif
    endtask

    task automatic pulse_start();
        bus.cmd_start = 1'b1;
        step();
        bus.cmd_start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < LIMIT) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d events outstanding after %0d cycles",
                     exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    task automatic run_sweep(input int s, input int e, input int st,
                             input int dw, input int md, input int npts);
        int last;
        push_model(s, e, st, dw, md, npts, last);
        set_cfg(s, e, st, dw, md);
        pulse_start();
        chk("err_cleared", int'(bus.cfg_err), 0);
        chk("busy_on_start", int'(bus.busy), 1);
        scramble_cfg();
        drain();
        if (md != 0) begin
            bus.cmd_abort = 1'b1;
            step();
            bus.cmd_abort = 1'b0;
            chk("abort_busy", int'(bus.busy), 0);
            chk("abort_hold", int'(bus.phase_M), last);
        end else begin
            step();
            chk("idle_busy", int'(bus.busy), 0);
            chk("idle_at_stop", int'(bus.phase_M), e);
        end
        repeat (2) step();
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int s, e, st, dw, md, ph0, last;
        bus.cfg_start_m = '0;
        bus.cfg_stop_m  = '0;
        bus.cfg_step    = '0;
        bus.cfg_dwell   = '0;
        bus.cfg_mode    = '0;
        bus.cmd_start   = 1'b0;
        bus.cmd_abort   = 1'b0;
`ifdef SWEEP_MARKER_EN
        bus.cfg_marker_m = '0;
`endif
        #2 rst = 1'b1;
        repeat (3) step();
        chk("rst_phase", int'(bus.phase_M), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.sweep_done), 0);
        chk("rst_err", int'(bus.cfg_err), 0);
        rst = 1'b0;
        mon_en = 1'b1;
        step();

        tick_all = 1'b1;
        run_sweep(100, 130, 10, 2, 0, 0);
        run_sweep(0, 25, 10, 1, 0, 0);
        run_sweep(50, 20, 15, 1, 2, 8);
        run_sweep(7, 7, 0, 0, 0, 0);

        ph0 = int'(bus.phase_M);
        set_cfg(5, 9, 0, 1, 0);
        pulse_start();
        chk("err_step0", int'(bus.cfg_err), 1);
        chk("err_step0_busy", int'(bus.busy), 0);
        chk("err_step0_phase", int'(bus.phase_M), ph0);
        repeat (3) step();
        chk("err_sticky", int'(bus.cfg_err), 1);
        run_sweep(300, 280, 7, 3, 1, 9);
        set_cfg(5, 9, 2, 1, 3);
        pulse_start();
        chk("err_mode3", int'(bus.cfg_err), 1);
        chk("err_mode3_busy", int'(bus.busy), 0);
        rst = 1'b1;
        #1;
        chk("rst_clears_err", int'(bus.cfg_err), 0);
        step();
        rst = 1'b0;
        step();

        push_model(200, 300, 10, 50, 1, 1, last);
        set_cfg(200, 300, 10, 50, 1);
        pulse_start();
        drain();
        repeat (3) step();
        set_cfg(900, 950, 5, 1, 0);
        pulse_start();
        chk("start_while_busy_phase", int'(bus.phase_M), 200);
        chk("start_while_busy_busy", int'(bus.busy), 1);
        bus.cmd_abort = 1'b1;
        bus.cmd_start = 1'b1;
        step();
        bus.cmd_abort = 1'b0;
        bus.cmd_start = 1'b0;
        chk("race_busy", int'(bus.busy), 0);
        chk("race_phase", int'(bus.phase_M), 200);
        repeat (3) step();
        chk("race_no_restart", int'(bus.busy), 0);

        for (int i = 0; i < 12; i++) begin
            md = $urandom_range(0, 2);
            s = $urandom_range(0, 2047);
            e = $urandom_range(0, 2047);
            if (md == 0 && $urandom_range(0, 4) == 0) e = s;
            if (md != 0 && e == s) e = (s + 1) % 2048;
            st = ((e > s) ? e - s : s - e) / $urandom_range(2, 25);
            st = st + $urandom_range(1, 40);
            dw = $urandom_range(0, 3);
            tick_all = ($urandom_range(0, 1) == 1);
            run_sweep(s, e, st, dw, md, $urandom_range(6, 30));
        end
        tick_all = 1'b1;

        push_model(0, 2000, 10, 1, 0, 0, last);
        set_cfg(0, 2000, 10, 1, 0);
        pulse_start();
        repeat (6) step();
        mon_en = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("async_rst_phase", int'(bus.phase_M), 0);
        chk("async_rst_busy", int'(bus.busy), 0);
        chk("async_rst_done", int'(bus.sweep_done), 0);
        exp_q.delete();
        step();
        rst = 1'b0;
        step();
        mon_en = 1'b1;
        step();

`ifdef SWEEP_MARKER_EN
        mark_m = 115;
        mark_cnt = 0;
        run_sweep(100, 130, 10, 1, 0, 0);
        chk("marker_count", mark_cnt, 1);
        chk("marker_value", mark_val, 120);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sweep_controller.md
Name: sweep_controller

Overview:
- Sequences the DDS phase increment word (phase_M) through a programmable linear frequency sweep: start value, stop value, step size and dwell time.
- Sits between control_unit and phase_accumulator; control_unit supplies the config fields and the start/abort commands.
- The DDS sample-rate enable (tick) paces the sweep, so the dwell time is counted in DDS samples.

Parameters:
- M_W, 11: phase_M width; instantiated with `ROM_PHASE_BIT-1.
- DWELL_W, 16: dwell counter width.

Ports:
- clk  in  1  DDS domain clock
- rst  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle sample enable; the dwell counter advances only on ticks
- cfg_start_m  in  M_W  first phase_M value
- cfg_stop_m  in  M_W  last phase_M value
- cfg_step  in  M_W  unsigned step magnitude
- cfg_dwell  in  DWELL_W  ticks per point; 0 is treated as 1
- cfg_mode  in  2  00 single, 01 sawtooth repeat, 10 triangle, 11 reserved
- cmd_start  in  1  pulse that begins a sweep
- cmd_abort  in  1  pulse that ends a sweep
- phase_M  out  M_W  tuning word to phase_accumulator
- busy  out  1  high while a sweep is running
- sweep_done  out  1  one-cycle pulse when a single-mode sweep completes
- cfg_err  out  1  sticky error flag; cleared by the next accepted cmd_start

Behaviour:
- Reset (async): state=IDLE, phase_M=0, busy=0, sweep_done=0, cfg_err=0, counters=0, dir=up.
- States: IDLE, DWELL, STEP, DONE.
- IDLE:
  - cmd_start=1 with valid config: latch all cfg_*, set dir = (stop>=start) ? up : down, load phase_M=start, load dwell_cnt = max(cfg_dwell,1), set busy=1, go to DWELL.
  - phase_M and busy change on the edge that samples cmd_start (1-cycle latency).
  - Invalid config: cfg_step=0 (when start!=stop) or cfg_mode=11. Set cfg_err=1, stay in IDLE, phase_M unchanged.
- Config inputs are ignored after latching; changing them mid-sweep has no effect.
- DWELL: on each tick, dwell_cnt decrements. When a tick arrives with dwell_cnt==1, go to STEP. Each point is held for exactly max(cfg_dwell,1) ticks.
- STEP (one clk cycle, no tick needed):
  - If phase_M==stop (up) or ==start (down, triangle return leg), the endpoint is handled by mode:
    - single: go to DONE.
    - sawtooth: phase_M=start, dir=initial dir.
    - triangle: reverse dir, then take one step in the new direction.
  - Otherwise next = phase_M ± step, clamped so it never passes the current target endpoint. The unclamped result is computed M_W+1 bits wide so no wrap-around occurs.
  - After any load of phase_M in STEP, reload dwell_cnt and return to DWELL.
- start==stop:
  - single: holds one dwell, then DONE.
  - sawtooth/triangle: holds the value indefinitely, re-dwelling; step is ignored.
- DONE (one cycle): sweep_done=1, busy=0, phase_M holds stop, go to IDLE.
- cmd_abort in any non-IDLE state: go to IDLE next edge, busy=0, phase_M holds its current value, no sweep_done.
- Command priority:
  - Abort beats start and tick in the same cycle.
  - cmd_start while busy is ignored.
- sweep_done is never asserted in sawtooth or triangle mode.

Optional Feature:
- Macro SWEEP_MARKER_EN.
- Defined: adds ports cfg_marker_m (in, M_W) and marker (out, 1).
  - marker pulses for one clk cycle on the edge where phase_M is loaded with a value that reaches or crosses cfg_marker_m in the current direction.
  - cfg_marker_m is latched at start.
  - marker resets to 0.
- Undefined: no such ports or logic.

Decomposition:
- Shared package / config.vh additions:
  - state encoding constants (SW_IDLE, SW_DWELL, SW_STEP, SW_DONE)
  - mode constants (SW_MODE_SINGLE=2'b00, SW_MODE_SAW=2'b01, SW_MODE_TRI=2'b10)
- One sub-module, sweep_next_value: combinational clamped add/subtract producing next value and an at_target flag.

Test Plan:
- Single up: start=100, stop=130, step=10, dwell=2, tick every cycle, cmd_start → phase_M = 100,110,120,130, each held 2 ticks; sweep_done pulses once; busy falls on the same edge.
- Clamp: start=0, stop=25, step=10, single → 0,10,20,25, then done; never exceeds 25.
- Triangle with down start: start=50, stop=20, step=15, dwell=1 → 50,35,20,35,50,35,… until cmd_abort; after abort busy=0 and phase_M holds its last value.
- Errors: cfg_step=0, start=5, stop=9 → cfg_err=1, busy stays 0. Then a valid cmd_start clears cfg_err.
- Command races: cmd_abort and cmd_start asserted together in DWELL → IDLE with no restart. Async rst asserted mid-sweep → all outputs 0 immediately.
- SWEEP_MARKER_EN: marker=115, sweep 100..130 step 10 → marker pulses once, on the load of 120.
